// File: rtl/uart_ring_bridge.sv
// UART <-> memory ring bridge: RX bytes go into an RX ring, and the TX ring is drained to the transmitter, all through one memory port.
// Defining UART_RING_BRIDGE_IRQ_EN adds a registered irq output.
module uart_ring_bridge #(
    parameter int AW        = 11,
    parameter int UART_BASE = 0,
    parameter int RXL       = 4,
    parameter int TXL       = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_ready,
    input  logic [7:0]     rx_data,
    input  logic           tx_ready,
    output logic           tx_en,
    output logic [7:0]     tx_data,
    output logic           mem_we,
    output logic           mem_re,
    output logic [AW-1:0]  mem_ad,
    output logic [7:0]     mem_wd,
    input  logic [7:0]     mem_rd,
    output logic [RXL-1:0] rx_wr_ptr,
    input  logic [RXL-1:0] rx_rd_ptr,
    input  logic [TXL-1:0] tx_wr_ptr,
    output logic [TXL-1:0] tx_rd_ptr,
    output logic           rx_overrun,
    input  logic           ovr_clr
`ifdef UART_RING_BRIDGE_IRQ_EN
    ,
    output logic           irq
`endif
);
    // state    | meaning
    // IDLE     | wait for held RX byte or TX work
    // RX_WR    | write held byte into RX ring
    // TX_RD    | read next TX ring byte
    // TX_WAIT  | memory data returns, captured into tx_data
    // TX_SEND  | tx_en strobe, advance tx_rd_ptr
    // TX_GUARD | ignore tx_ready while transmitter goes busy
    typedef enum logic [2:0] {IDLE, RX_WR, TX_RD, TX_WAIT, TX_SEND, TX_GUARD} state_t;

    localparam logic [AW-1:0] RX_BASE = AW'(UART_BASE);
    localparam logic [AW-1:0] TX_BASE = AW'(UART_BASE + 2**RXL);

    state_t     state, state_nx;
    logic [7:0] rx_hold;
    logic       rx_pend;
    logic       rx_full, tx_empty, ovr_event;

    assign rx_full   = (rx_wr_ptr + RXL'(1)) == rx_rd_ptr;
    assign tx_empty  = tx_rd_ptr == tx_wr_ptr;
    // A retiring hold frees the register this cycle, so that strobe is not an overrun.
    assign ovr_event = rx_ready && rx_pend && (state != RX_WR);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (rx_pend && !rx_full)
                    state_nx = RX_WR;
                else if (!tx_empty && tx_ready)
                    state_nx = TX_RD;
            end
            RX_WR:    state_nx = IDLE;
            TX_RD:    state_nx = TX_WAIT;
            TX_WAIT:  state_nx = TX_SEND;
            TX_SEND:  state_nx = TX_GUARD;
            TX_GUARD: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_hold    <= 8'h00;
            rx_pend    <= 1'b0;
            rx_overrun <= 1'b0;
            rx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            tx_en      <= 1'b0;
            tx_data    <= 8'h00;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_ad     <= '0;
            mem_wd     <= 8'h00;
        end else begin
            state  <= state_nx;
            // Strobes are registered from the next state so they line up with that state.
            mem_we <= (state_nx == RX_WR);
            mem_re <= (state_nx == TX_RD);
            tx_en  <= (state_nx == TX_SEND);
            if (state_nx == RX_WR) begin
                mem_ad <= RX_BASE + AW'(rx_wr_ptr);
                mem_wd <= rx_hold;
            end
            if (state_nx == TX_RD)
                mem_ad <= TX_BASE + AW'(tx_rd_ptr);
            if (state == TX_WAIT)
                tx_data <= mem_rd;
            if (state == RX_WR)
                rx_wr_ptr <= rx_wr_ptr + RXL'(1);
            if (state == TX_SEND)
                tx_rd_ptr <= tx_rd_ptr + TXL'(1);

            if (rx_ready && (!rx_pend || state == RX_WR)) begin
                rx_hold <= rx_data;
                rx_pend <= 1'b1;
            end else if (state == RX_WR) begin
                rx_pend <= 1'b0;
            end

            if (ovr_event)
                rx_overrun <= 1'b1;
            else if (ovr_clr)
                rx_overrun <= 1'b0;
        end
    end

`ifdef UART_RING_BRIDGE_IRQ_EN
    logic tx_empty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq        <= 1'b0;
            tx_empty_q <= 1'b1;
        end else begin
            tx_empty_q <= tx_empty;
            irq        <= (rx_wr_ptr != rx_rd_ptr) | rx_overrun | (tx_empty & ~tx_empty_q);
        end
    end
`endif

endmodule

// File: tb/tb_uart_ring_bridge.sv
// Directed bench for uart_ring_bridge: RX ring fill/overrun/wrap, TX drain, RX/TX collision, mid-TX reset.
module tb_uart_ring_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b0;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        mem_we, mem_re;
    logic [10:0] mem_ad;
    logic [7:0]  mem_wd;
    logic [7:0]  mem_rd = 8'h00;
    logic [3:0]  rx_wr_ptr;
    logic [3:0]  rx_rd_ptr = 4'd0;
    logic [3:0]  tx_wr_ptr = 4'd0;
    logic [3:0]  tx_rd_ptr;
    logic        rx_overrun;
    logic        ovr_clr = 1'b0;
`ifdef UART_RING_BRIDGE_IRQ_EN
    logic        irq;
`endif

    uart_ring_bridge dut (
        .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_en(tx_en), .tx_data(tx_data),
        .mem_we(mem_we), .mem_re(mem_re), .mem_ad(mem_ad), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .rx_wr_ptr(rx_wr_ptr), .rx_rd_ptr(rx_rd_ptr),
        .tx_wr_ptr(tx_wr_ptr), .tx_rd_ptr(tx_rd_ptr),
        .rx_overrun(rx_overrun), .ovr_clr(ovr_clr)
`ifdef UART_RING_BRIDGE_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: synchronous read, data valid the cycle after mem_re; tb port for preloading.
    logic [7:0]  mem [0:2047];
    logic        tb_we = 1'b0;
    logic [10:0] tb_ad = '0;
    logic [7:0]  tb_wd = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_ad] <= mem_wd;
        if (tb_we)  mem[tb_ad] <= tb_wd;
        if (mem_re) mem_rd <= mem[mem_ad];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          w_ad[$], w_d[$], w_cyc[$];
    int          r_ad[$], r_cyc[$];
    int          t_d[$], t_cyc[$];
    int          overlap = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin w_ad.push_back(int'(mem_ad)); w_d.push_back(int'(mem_wd)); w_cyc.push_back(cyc); end
            if (mem_re) begin r_ad.push_back(int'(mem_ad)); r_cyc.push_back(cyc); end
            if (tx_en)  begin t_d.push_back(int'(tx_data)); t_cyc.push_back(cyc); end
            if (mem_we && mem_re) overlap = overlap + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        w_ad.delete(); w_d.delete(); w_cyc.delete();
        r_ad.delete(); r_cyc.delete();
        t_d.delete(); t_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rx_ready = 1'b0; tx_ready = 1'b0; ovr_clr = 1'b0;
        rx_rd_ptr = 4'd0; tx_wr_ptr = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    // Returns at the negedge after the strobe cycle.
    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        rx_ready = 1'b1; rx_data = b;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic poke(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_ad = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx_en", tx_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_ovr", rx_overrun, 0);
        check("rst_ad", mem_ad, 0);
        check("rst_ptrs", {rx_wr_ptr, tx_rd_ptr}, 0);
        rst = 1'b0;

        // Single RX byte: mem_we two cycles after rx_ready
        clear_logs();
        rx_byte(8'h41);
        check("rx1_we_early", mem_we, 0);
        @(negedge clk);
        check("rx1_we", mem_we, 1);
        check("rx1_ad", mem_ad, 11'h000);
        check("rx1_wd", mem_wd, 8'h41);
        @(negedge clk);
        check("rx1_ptr", rx_wr_ptr, 1);
        check("rx1_we_off", mem_we, 0);
`ifdef UART_RING_BRIDGE_IRQ_EN
        @(negedge clk);
        check("irq_rx_nonempty", irq, 1);
`endif

        // Fill the RX ring: 15 writes, 16th held, 17th overruns
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rx_byte(8'(i));
            repeat (3) @(negedge clk);
        end
        check("fill_count", w_ad.size(), 15);
        for (int i = 0; i < 15 && i < w_ad.size(); i++) begin
            check("fill_ad", w_ad[i], i);
            check("fill_wd", w_d[i], i);
        end
        check("fill_ptr", rx_wr_ptr, 15);
        check("fill_no_ovr", rx_overrun, 0);
        rx_byte(8'hEE);
        check("ovr_set", rx_overrun, 1);
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        check("ovr_clr", rx_overrun, 0);
        @(negedge clk); rx_ready = 1'b1; rx_data = 8'hDD; ovr_clr = 1'b1;
        @(negedge clk); rx_ready = 1'b0; ovr_clr = 1'b0;
        check("ovr_wins_clr", rx_overrun, 1);
        clear_logs();
        rx_rd_ptr = 4'd1;
        repeat (4) @(negedge clk);
        check("wrap_count", w_ad.size(), 1);
        if (w_ad.size() > 0) begin
            check("wrap_ad", w_ad[0], 11'h00F);
            check("wrap_wd", w_d[0], 8'h0F);
        end
        check("wrap_ptr", rx_wr_ptr, 0);

        // TX drain of two bytes
        do_reset();
        poke(11'h010, 8'h55);
        poke(11'h011, 8'h66);
        @(negedge clk);
        tx_wr_ptr = 4'd2; tx_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("tx_rd_count", r_ad.size(), 2);
        if (r_ad.size() == 2) begin
            check("tx_rd_ad0", r_ad[0], 11'h010);
            check("tx_rd_ad1", r_ad[1], 11'h011);
        end
        check("tx_en_count", t_d.size(), 2);
        if (t_d.size() == 2) begin
            check("tx_d0", t_d[0], 8'h55);
            check("tx_d1", t_d[1], 8'h66);
        end
        if (t_cyc.size() > 0 && r_cyc.size() > 0)
            check("tx_latency", t_cyc[0] - r_cyc[0], 2);
        check("tx_ptr", tx_rd_ptr, 2);

        // RX strobe in the same cycle as the IDLE TX decision
        do_reset();
        poke(11'h010, 8'h77);
        @(negedge clk);
        tx_wr_ptr = 4'd1;
        @(negedge clk);
        tx_ready = 1'b1; rx_ready = 1'b1; rx_data = 8'h99;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (12) @(negedge clk);
        check("col_tx_count", t_d.size(), 1);
        if (t_d.size() > 0) check("col_tx_d", t_d[0], 8'h77);
        check("col_wr_count", w_ad.size(), 1);
        if (w_ad.size() > 0) begin
            check("col_wr_ad", w_ad[0], 11'h000);
            check("col_wr_d", w_d[0], 8'h99);
        end
        if (w_cyc.size() > 0 && t_cyc.size() > 0)
            check("col_order", w_cyc[0] > t_cyc[0], 1);
        check("col_no_ovr", rx_overrun, 0);
        check("we_re_overlap", overlap, 0);

        // Reset during TX_WAIT
        do_reset();
        @(negedge clk);
        tx_wr_ptr = 4'd1; tx_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_re", mem_re, 1);
        @(negedge clk);
        rst = 1'b1; tx_ready = 1'b0; tx_wr_ptr = 4'd0;
        @(negedge clk);
        check("mid_rst_out", {tx_en, mem_we, mem_re, rx_overrun}, 0);
        check("mid_rst_data", {tx_data, mem_wd}, 0);
        check("mid_rst_ad", mem_ad, 0);
        check("mid_rst_ptr", tx_rd_ptr, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_rst_no_tx", t_d.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
